// File: rtl/json_drive_cmd_tx_pkg.sv
// Shared constants and types for the run-time formatted JSON drive command sender.
// Holds the ASCII set, the fixed frame fragments and the FSM state encoding.
package json_cmd_pkg;

  localparam logic [7:0] ASCII_LBRACE = 8'h7B;
  localparam logic [7:0] ASCII_RBRACE = 8'h7D;
  localparam logic [7:0] ASCII_QUOTE  = 8'h22;
  localparam logic [7:0] ASCII_COLON  = 8'h3A;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_NL     = 8'h0A;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;

  localparam int FRAME_MIN  = 26;
  localparam int FRAME_MAX  = 28;
  localparam int PREFIX_LEN = 11;
  localparam int MIDDLE_LEN = 5;

  // Index 0 is the first byte on the wire
  localparam logic [0:10][7:0] PREFIX = {ASCII_LBRACE, ASCII_QUOTE, 8'h54, ASCII_QUOTE,
                                         ASCII_COLON, 8'h31, ASCII_COMMA, ASCII_QUOTE,
                                         8'h4C, ASCII_QUOTE, ASCII_COLON};
  localparam logic [0:4][7:0] MIDDLE = {ASCII_COMMA, ASCII_QUOTE, 8'h52, ASCII_QUOTE,
                                        ASCII_COLON};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV_L,
    ST_CONV_R,
    ST_SEND
  } state_t;

  typedef logic [0:4][7:0] text_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/json_drive_cmd_tx_if.sv
// Command and byte-stream handshakes of the JSON drive command sender.
// The slave modport is the sender itself; master is the side feeding it commands and taking bytes.
interface json_drive_cmd_tx_if #(
  parameter int VAL_W = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [VAL_W-1:0] cmd_left;
  logic signed [VAL_W-1:0] cmd_right;
  logic [7:0]              byte_data;
  logic                    byte_valid;
  logic                    byte_ready;

  modport master (
    output cmd_valid, cmd_left, cmd_right, byte_ready,
    input  cmd_ready, byte_data, byte_valid
  );

  modport slave (
    input  cmd_valid, cmd_left, cmd_right, byte_ready,
    output cmd_ready, byte_data, byte_valid
  );
endinterface

// File: rtl/json_drive_cmd_tx_speed_to_ascii.sv
// Formats a signed hundredths value as "[-]d.dd", saturating the magnitude at 1.00.
// Purely combinational; digits come from a compare chain so no divider is built.
module speed_to_ascii
  import json_cmd_pkg::*;
#(
  parameter int VAL_W = 8
) (
  input  logic signed [VAL_W-1:0] value,
  output text_t                   chars,
  output logic [2:0]              len
);

  logic             neg;
  logic             hundreds;
  logic [VAL_W:0]   ext;
  logic [VAL_W:0]   mag_full;
  logic [6:0]       sat;
  logic [6:0]       rem;
  logic [6:0]       base;
  logic [3:0]       tens;
  logic [3:0]       units;

  // One extra bit keeps the most negative input representable after negation
  always_comb begin
    neg      = value[VAL_W-1];
    ext      = {value[VAL_W-1], value};
    mag_full = neg ? (~ext + (VAL_W+1)'(1)) : ext;
    sat      = (mag_full > (VAL_W+1)'(100)) ? 7'd100 : mag_full[6:0];
    hundreds = (sat == 7'd100);
    rem      = hundreds ? 7'd0 : sat;
    tens     = 4'd0;
    base     = 7'd0;
    for (int k = 1; k < 10; k++) begin
      if (rem >= 7'(k * 10)) begin
        tens = 4'(k);
        base = 7'(k * 10);
      end
    end
    units = 4'(rem - base);
    if (neg) begin
      chars = {ASCII_MINUS, digit_char({3'b000, hundreds}), ASCII_DOT,
               digit_char(tens), digit_char(units)};
      len   = 3'd5;
    end else begin
      chars = {digit_char({3'b000, hundreds}), ASCII_DOT, digit_char(tens),
               digit_char(units), 8'h00};
      len   = 3'd4;
    end
  end

endmodule

// File: rtl/json_drive_cmd_tx.sv
// Accepts left/right wheel speeds and streams {"T":1,"L":<l>,"R":<r>}\n byte by byte to uart_tx.
// An idle heartbeat re-sends the last command so the rover never acts on a stale frame.
module json_drive_cmd_tx
  import json_cmd_pkg::*;
#(
  parameter int VAL_W            = 8,
  parameter int HEARTBEAT_CYCLES = 25_000_000,
  parameter int CNT_W            = 16
) (
  input  logic              clk,
  input  logic              rst,
  json_drive_cmd_tx_if.slave bus,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int              HB_W    = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam bit              HB_EN   = (HEARTBEAT_CYCLES != 0);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);

  state_t                  state;
  logic signed [VAL_W-1:0] stored_l;
  logic signed [VAL_W-1:0] stored_r;
  logic signed [VAL_W-1:0] conv_in;
  text_t                   conv_chars;
  text_t                   txt_l;
  text_t                   txt_r;
  logic [2:0]              conv_len;
  logic [2:0]              len_l;
  logic [2:0]              len_r;
  logic [4:0]              idx;
  logic [4:0]              sel_idx;
  logic [4:0]              l_end;
  logic [4:0]              m_end;
  logic [4:0]              r_end;
  logic [4:0]              last_idx;
  logic [7:0]              sel_byte;
  logic [HB_W-1:0]         hb_cnt;
  logic                    byte_valid_q;
  logic [7:0]              byte_data_q;
  logic                    cmd_ready_q;

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.cmd_ready  = cmd_ready_q;

  assign conv_in = (state == ST_CONV_L) ? stored_l : stored_r;

  speed_to_ascii #(.VAL_W(VAL_W)) u_fmt (
    .value (conv_in),
    .chars (conv_chars),
    .len   (conv_len)
  );

  // Byte to load next: the first byte when valid is still low, otherwise the one after idx
  always_comb begin
    sel_idx  = byte_valid_q ? (idx + 5'd1) : 5'd0;
    l_end    = 5'(PREFIX_LEN) + {2'b00, len_l};
    m_end    = l_end + 5'(MIDDLE_LEN);
    r_end    = m_end + {2'b00, len_r};
    last_idx = r_end + 5'd1;
    if (sel_idx < 5'(PREFIX_LEN))  sel_byte = PREFIX[sel_idx[3:0]];
    else if (sel_idx < l_end)      sel_byte = txt_l[3'(sel_idx - 5'(PREFIX_LEN))];
    else if (sel_idx < m_end)      sel_byte = MIDDLE[3'(sel_idx - l_end)];
    else if (sel_idx < r_end)      sel_byte = txt_r[3'(sel_idx - m_end)];
    else if (sel_idx == r_end)     sel_byte = ASCII_RBRACE;
    else                           sel_byte = ASCII_NL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      stored_l     <= '0;
      stored_r     <= '0;
      txt_l        <= '0;
      txt_r        <= '0;
      len_l        <= 3'd4;
      len_r        <= 3'd4;
      idx          <= 5'd0;
      hb_cnt       <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      cmd_ready_q  <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frames_sent  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            stored_l    <= bus.cmd_left;
            stored_r    <= bus.cmd_right;
            hb_cnt      <= '0;
            state       <= ST_CONV_L;
            cmd_ready_q <= 1'b0;
            busy        <= 1'b1;
          end else if (HB_EN && hb_cnt == HB_LAST) begin
            hb_cnt      <= '0;
            state       <= ST_CONV_L;
            cmd_ready_q <= 1'b0;
            busy        <= 1'b1;
          end else if (HB_EN) begin
            hb_cnt <= hb_cnt + HB_W'(1);
          end
        end
        ST_CONV_L: begin
          txt_l <= conv_chars;
          len_l <= conv_len;
          state <= ST_CONV_R;
        end
        ST_CONV_R: begin
          txt_r <= conv_chars;
          len_r <= conv_len;
          idx   <= 5'd0;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (!byte_valid_q) begin
            byte_valid_q <= 1'b1;
            byte_data_q  <= sel_byte;
          end else if (bus.byte_ready) begin
            if (idx == last_idx) begin
              byte_valid_q <= 1'b0;
              frame_done   <= 1'b1;
              frames_sent  <= frames_sent + CNT_W'(1);
              hb_cnt       <= '0;
              cmd_ready_q  <= 1'b1;
              busy         <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              idx         <= idx + 5'd1;
              byte_data_q <= sel_byte;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
